sbqm: RTL and testbench
=======================

Name: sbqm

Overview:
Smart bank queue manager. Counts customers in a single waiting queue, using an entry sensor and an exit (teller) sensor. Outputs the occupancy count, full and empty flags, and an estimated waiting time based on the number of active tellers. Sits between the door/teller sensor front-end and the customer display logic.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on each sensor input (legal range 2..3)
SERVICE_TIME, 3, time units per customer per teller used in the wait estimate (legal range 1..4, so the result fits in 5 bits)

Ports:
clk  input  1  system clock; all state updates on rising edge
RESET  input  1  asynchronous, active-low reset
sensor_start  input  1  entry sensor, active-low; idles high; asynchronous to clk
sensor_end  input  1  exit/teller sensor, active-low; idles high; asynchronous to clk
Tellers_count  input  2  number of active tellers (0..3); quasi-static
People_count  output  3  current queue occupancy (0..7)
Full_flag  output  1  high when People_count == 7
Empty_flag  output  1  high when People_count == 0
WaitTime  output  5  estimated wait in time units

Behaviour:
- Reset: asynchronous on RESET low.
  - People_count=0, Empty_flag=1, Full_flag=0, WaitTime=0.
  - All synchronizer and edge-detect flops preset to 1 (idle level), so no spurious event is detected on reset release.
- Input conditioning: each sensor passes through a SYNC_STAGES flop chain. An event is a 1->0 transition of the synchronized signal, detected as prev=1, cur=0.
  - One event per falling edge; holding a sensor low produces no further events.
  - Rising edges are ignored.
- Latency: People_count changes on the (SYNC_STAGES+1)th rising clk edge after the sensor falls, with the input held stable.
- Count update per cycle, s=start event, e=end event:
  - s only: +1 if count<7, otherwise hold at 7 (overflow ignored).
  - e only: -1 if count>0, otherwise hold at 0 (underflow ignored).
  - s and e with 0<count<7: count unchanged.
  - s and e with count==7: hold at 7.
  - s and e with count==0: becomes 1 (end event ignored, queue was empty).
  - No events: hold.
- Count arithmetic is saturating; it never wraps.
- Flags: combinational decode of the People_count register; valid in the same cycle as the count.
- WaitTime: registered; updated one clk cycle after People_count or Tellers_count changes.
  - If count P==0: WaitTime=0.
  - Otherwise: WaitTime = floor(SERVICE_TIME*(P+T-1)/T), where T=Tellers_count, and T==0 is treated as T=1.
  - Implement as a combinational lookup or small constant divider; no iterative divider, no multi-cycle latency.
- Reset mid-operation: immediate return to reset values; sensors must return high and fall again to be counted.

Optional Feature:
Macro SBQM_STATUS_EN.
- Defined: adds two outputs, overflow_err and underflow_err (1 bit each, reset 0).
  - overflow_err: one-cycle pulse when a lone start event arrives with count==7.
  - underflow_err: one-cycle pulse when a lone end event arrives with count==0.
  - The simultaneous-event cases above never pulse either output.
- Not defined: ports absent. Count, flag and WaitTime behaviour is identical in both builds.

Test Plan:
- Reset and idle: RESET=0, then RESET=1 with both sensors high and T=1 -> count=0, Empty=1, Full=0, WaitTime=0; no change over 20 cycles.
- Fill with T=1: 8 start pulses.
  - Counts 1..7.
  - At 7: Full=1, Empty=0, WaitTime=21.
  - 8th pulse: count stays 7 (overflow_err pulses if enabled).
  - After 1st pulse: WaitTime=3.
- Drain with T=1: 8 end pulses from 7 -> 6..0. At 0: Empty=1, WaitTime=0. 8th pulse holds at 0 (underflow_err pulses if enabled).
- Teller scaling at P=7: T=2 -> WaitTime=12; T=3 -> WaitTime=9.
  - Also P=2,T=2 -> 4; P=4,T=3 -> 6; T=0 gives the same results as T=1.
  - Each change appears one cycle after Tellers_count changes.
- Simultaneous events: both sensors fall in the same cycle.
  - At count=3 -> 3.
  - At 0 -> 1.
  - At 7 -> 7.
- Edge/reset robustness:
  - Sensor held low for 10 cycles -> exactly one increment.
  - RESET asserted mid-fill at count=5 -> immediately 0, Empty=1, WaitTime=0.

Source files
------------

// File: rtl/sbqm_if.sv
// Sensor, teller and display signals of the bank queue manager.
// SBQM_STATUS_EN adds the overflow/underflow status outputs.
interface sbqm_if;
  logic       sensor_start;
  logic       sensor_end;
  logic [1:0] Tellers_count;
  logic [2:0] People_count;
  logic       Full_flag;
  logic       Empty_flag;
  logic [4:0] WaitTime;
`ifdef SBQM_STATUS_EN
  logic       overflow_err;
  logic       underflow_err;
`endif

  modport master (
    output sensor_start,
    output sensor_end,
    output Tellers_count,
    input  People_count,
    input  Full_flag,
    input  Empty_flag,
`ifdef SBQM_STATUS_EN
    input  overflow_err,
    input  underflow_err,
`endif
    input  WaitTime
  );

  modport slave (
    input  sensor_start,
    input  sensor_end,
    input  Tellers_count,
    output People_count,
    output Full_flag,
    output Empty_flag,
`ifdef SBQM_STATUS_EN
    output overflow_err,
    output underflow_err,
`endif
    output WaitTime
  );
endinterface

// File: rtl/sbqm.sv
// Bank queue manager: saturating occupancy counter driven by two falling-edge sensors,
// with flags and a registered wait estimate. SBQM_STATUS_EN adds overflow/underflow pulses.
module sbqm #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SERVICE_TIME = 3
) (
  input logic   clk,
  input logic   RESET,
  sbqm_if.slave bus
);

  logic [SYNC_STAGES-1:0] r_sync_start;
  logic [SYNC_STAGES-1:0] r_sync_end;
  logic                   r_prev_start;
  logic                   r_prev_end;
  logic [2:0]             r_count;
  logic [2:0]             w_count_d;
  logic [4:0]             r_wait;
  logic                   w_s;
  logic                   w_e;
  logic [1:0]             w_teff;
  logic [3:0]             w_sum;
  logic [6:0]             w_num;
  logic [6:0]             w_quot;
  logic [4:0]             w_wait_d;

  // Flops preset to the idle-high level so reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_sync_start <= '1;
      r_sync_end   <= '1;
      r_prev_start <= 1'b1;
      r_prev_end   <= 1'b1;
    end else begin
      r_sync_start <= {r_sync_start[SYNC_STAGES-2:0], bus.sensor_start};
      r_sync_end   <= {r_sync_end[SYNC_STAGES-2:0], bus.sensor_end};
      r_prev_start <= r_sync_start[SYNC_STAGES-1];
      r_prev_end   <= r_sync_end[SYNC_STAGES-1];
    end
  end

  assign w_s = r_prev_start & ~r_sync_start[SYNC_STAGES-1];
  assign w_e = r_prev_end & ~r_sync_end[SYNC_STAGES-1];

  always_comb begin
    w_count_d = r_count;
    unique case ({w_s, w_e})
      2'b10: if (r_count != 3'd7) w_count_d = r_count + 3'd1;
      2'b01: if (r_count != 3'd0) w_count_d = r_count - 3'd1;
      // End event on an empty queue has no customer to remove.
      2'b11: if (r_count == 3'd0) w_count_d = 3'd1;
      default: w_count_d = r_count;
    endcase
  end

  always_comb begin
    w_teff = (bus.Tellers_count == 2'd0) ? 2'd1 : bus.Tellers_count;
    w_sum  = 4'(r_count) + 4'(w_teff) - 4'd1;
    w_num  = 7'(SERVICE_TIME) * 7'(w_sum);
    w_quot = w_num;
    unique case (w_teff)
      2'd2:    w_quot = w_num >> 1;
      2'd3:    w_quot = w_num / 7'd3;
      default: w_quot = w_num;
    endcase
    w_wait_d = (r_count == 3'd0) ? 5'd0 : w_quot[4:0];
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_count <= 3'd0;
      r_wait  <= 5'd0;
    end else begin
      r_count <= w_count_d;
      r_wait  <= w_wait_d;
    end
  end

`ifdef SBQM_STATUS_EN
  logic r_ovf;
  logic r_unf;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_s & ~w_e & (r_count == 3'd7);
      r_unf <= w_e & ~w_s & (r_count == 3'd0);
    end
  end

  assign bus.overflow_err  = r_ovf;
  assign bus.underflow_err = r_unf;
`endif

  assign bus.People_count = r_count;
  assign bus.Full_flag    = (r_count == 3'd7);
  assign bus.Empty_flag   = (r_count == 3'd0);
  assign bus.WaitTime     = r_wait;

endmodule

// File: tb/tb_sbqm.sv
// Directed bench for sbqm (SYNC_STAGES=2, SERVICE_TIME=3); define SBQM_STATUS_EN to
// also cover the status pulses.
module tb_sbqm;
  logic clk;
  logic RESET;
  int   checks;
  int   errors;

  sbqm_if u_if ();

  sbqm #(
    .SYNC_STAGES (2),
    .SERVICE_TIME(3)
  ) u_dut (
    .clk  (clk),
    .RESET(RESET),
    .bus  (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int p, input int w);
    chk({tag, ".count"}, 32'(u_if.People_count), 32'(p));
    chk({tag, ".full"},  32'(u_if.Full_flag),    32'(p == 7));
    chk({tag, ".empty"}, 32'(u_if.Empty_flag),   32'(p == 0));
    chk({tag, ".wait"},  32'(u_if.WaitTime),     32'(w));
  endtask

  // Drop the selected sensors and stop just after the edge where the count reacts.
  task automatic fall(input bit s, input bit e);
    @(posedge clk); #1;
    if (s) u_if.sensor_start = 1'b0;
    if (e) u_if.sensor_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic rise();
    u_if.sensor_start = 1'b1;
    u_if.sensor_end   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic set_tellers(input logic [1:0] t);
    @(posedge clk); #1;
    u_if.Tellers_count = t;
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESET = 1'b0;
    u_if.sensor_start  = 1'b1;
    u_if.sensor_end    = 1'b1;
    u_if.Tellers_count = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    chk_state("reset", 0, 0);
    RESET = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk_state("idle", 0, 0);

    // First start pulse: count moves on the 3rd edge, WaitTime one edge later.
    @(posedge clk); #1;
    u_if.sensor_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("lat.before", 32'(u_if.People_count), 32'd0);
    @(posedge clk); #1;
    chk("lat.count", 32'(u_if.People_count), 32'd1);
    chk("lat.wait0", 32'(u_if.WaitTime), 32'd0);
    @(posedge clk); #1;
    chk("lat.wait1", 32'(u_if.WaitTime), 32'd3);
    rise();

    for (int i = 2; i <= 7; i++) begin
      fall(1'b1, 1'b0);
      rise();
      chk_state($sformatf("fill%0d", i), i, 3 * i);
    end

    set_tellers(2'd2);
    chk("t2p7", 32'(u_if.WaitTime), 32'd12);
    set_tellers(2'd3);
    chk("t3p7", 32'(u_if.WaitTime), 32'd9);
    set_tellers(2'd0);
    chk("t0p7", 32'(u_if.WaitTime), 32'd21);
    set_tellers(2'd1);

    fall(1'b1, 1'b0);
    chk("ovf.count", 32'(u_if.People_count), 32'd7);
`ifdef SBQM_STATUS_EN
    chk("ovf.pulse", 32'(u_if.overflow_err), 32'd1);
    @(posedge clk); #1;
    chk("ovf.clear", 32'(u_if.overflow_err), 32'd0);
`endif
    rise();
    chk_state("ovf.hold", 7, 21);

    for (int i = 6; i >= 0; i--) begin
      fall(1'b0, 1'b1);
      rise();
      chk_state($sformatf("drain%0d", i), i, 3 * i);
      if (i == 4) begin
        set_tellers(2'd3);
        chk("t3p4", 32'(u_if.WaitTime), 32'd6);
        set_tellers(2'd0);
        chk("t0p4", 32'(u_if.WaitTime), 32'd12);
        set_tellers(2'd1);
      end
      if (i == 2) begin
        set_tellers(2'd2);
        chk("t2p2", 32'(u_if.WaitTime), 32'd4);
        set_tellers(2'd0);
        chk("t0p2", 32'(u_if.WaitTime), 32'd6);
        set_tellers(2'd1);
      end
    end

    fall(1'b0, 1'b1);
    chk("unf.count", 32'(u_if.People_count), 32'd0);
`ifdef SBQM_STATUS_EN
    chk("unf.pulse", 32'(u_if.underflow_err), 32'd1);
    @(posedge clk); #1;
    chk("unf.clear", 32'(u_if.underflow_err), 32'd0);
`endif
    rise();
    chk_state("unf.hold", 0, 0);

    fall(1'b1, 1'b1);
    chk("sim0.count", 32'(u_if.People_count), 32'd1);
`ifdef SBQM_STATUS_EN
    chk("sim0.ovf", 32'(u_if.overflow_err), 32'd0);
    chk("sim0.unf", 32'(u_if.underflow_err), 32'd0);
`endif
    rise();
    chk_state("sim0", 1, 3);

    repeat (2) begin
      fall(1'b1, 1'b0);
      rise();
    end
    fall(1'b1, 1'b1);
    rise();
    chk_state("sim3", 3, 9);

    repeat (4) begin
      fall(1'b1, 1'b0);
      rise();
    end
    fall(1'b1, 1'b1);
`ifdef SBQM_STATUS_EN
    chk("sim7.ovf", 32'(u_if.overflow_err), 32'd0);
    chk("sim7.unf", 32'(u_if.underflow_err), 32'd0);
`endif
    rise();
    chk_state("sim7", 7, 21);

    RESET = 1'b0;
    #1;
    chk_state("rst7", 0, 0);
    RESET = 1'b1;

    // Held-low sensor yields a single event.
    @(posedge clk); #1;
    u_if.sensor_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk_state("hold", 1, 3);
    rise();
    chk_state("hold.rel", 1, 3);

    repeat (4) begin
      fall(1'b1, 1'b0);
      rise();
    end
    chk_state("fill5", 5, 15);
    @(posedge clk); #1;
    RESET = 1'b0;
    #1;
    chk_state("rst5", 0, 0);
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_state("rst5.idle", 0, 0);
    fall(1'b1, 1'b0);
    rise();
    chk_state("rst5.after", 1, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
